mem_arbiter: RTL and testbench

Two-port arbiter sharing the single 256-bit Data_Memory line port between the instruction-side and data-side cache controllers. Each requester issues a line read or write with a level enable and waits for a one-cycle ack. The arbiter latches the winning request, drives the memory enable/write/address/data handshake, and routes the ack back. It sits between the caches inside CPU and the external Data_Memory.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the two cache-side requesters, the arbiter and the Data_Memory line port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256
);
   // Requester handshake: req_i is a level that acts as valid and is held with
   // write/addr/data stable until the one-cycle ack_o, which acts as ready/done.
   // Memory handshake: mem_enable_o is valid, held until a one-cycle mem_ack_i.
   logic              m0_req_i;
   logic              m0_write_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [DATA_W-1:0] m0_data_i;
   logic              m0_ack_o;

   logic              m1_req_i;
   logic              m1_write_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [DATA_W-1:0] m1_data_i;
   logic              m1_ack_o;

   logic [DATA_W-1:0] rdata_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_data_i;
   logic              busy_o;

   modport slave (
      input  m0_req_i, m0_write_i, m0_addr_i, m0_data_i,
      input  m1_req_i, m1_write_i, m1_addr_i, m1_data_i,
      input  mem_ack_i, mem_data_i,
      output m0_ack_o, m1_ack_o, rdata_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, busy_o
   );

   modport master (
      output m0_req_i, m0_write_i, m0_addr_i, m0_data_i,
      output m1_req_i, m1_write_i, m1_addr_i, m1_data_i,
      output mem_ack_i, mem_data_i,
      input  m0_ack_o, m1_ack_o, rdata_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, busy_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port line arbiter (I-cache port 0, D-cache port 1) in front of Data_Memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise port 1 wins ties.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256
) (
   input  logic         clk_i,
   input  logic         rst_i,
   mem_arbiter_if.slave bus,
   output logic [1:0]   state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              any_req;
   logic              winner;
   logic              ack_hit;

   assign any_req = bus.m0_req_i | bus.m1_req_i;

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;

   // On a tie the port that was not served last goes first.
   always_comb begin
      winner = bus.m1_req_i;
      if (bus.m0_req_i && bus.m1_req_i) begin
         winner = ~last_q;
      end
   end

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && any_req) begin
         last_d = winner;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      winner = bus.m1_req_i;
   end
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      write_d = write_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = winner;
               write_d = winner ? bus.m1_write_i : bus.m0_write_i;
               addr_d  = winner ? bus.m1_addr_i  : bus.m0_addr_i;
               data_d  = winner ? bus.m1_data_i  : bus.m0_data_i;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (bus.mem_ack_i) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // The memory port is driven only from latched values, so requester churn is invisible here.
   assign ack_hit          = (state_q == BUSY) && bus.mem_ack_i;
   assign bus.m0_ack_o     = ack_hit && !grant_q;
   assign bus.m1_ack_o     = ack_hit && grant_q;
   assign bus.rdata_o      = bus.mem_data_i;
   assign bus.mem_enable_o = (state_q == BUSY);
   assign bus.mem_write_o  = (state_q == BUSY) && write_q;
   assign bus.mem_addr_o   = addr_q;
   assign bus.mem_data_o   = data_q;
   assign bus.busy_o       = (state_q != IDLE);
   assign state_o          = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural Data_Memory responder, directed scenarios and
// randomized request rounds checked against a transaction-level reference.
module tb_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 256;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] state_dbg;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (bus),
      .state_o (state_dbg)
   );

   // ---------------- Data_Memory responder ----------------
   logic [DATA_W-1:0] mem_store [64];
   logic [DATA_W-1:0] ref_mem [64];
   logic              model_ack;
   logic              spur_ack;
   int                lat_cfg;
   int                cnt;
   logic [5:0]        mline;
   logic              ref_last;

   assign bus.mem_ack_i = model_ack | spur_ack;
   assign mline = bus.mem_addr_o[10:5];

   function automatic logic [DATA_W-1:0] init_line(input int i);
      logic [31:0] w;
      w = 32'h5A00_0000 + i;
      if (i == 2) w = 32'hECFA_ECFA;
      return {8{w}};
   endfunction

   function automatic logic [DATA_W-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [ADDR_W-1:0] line_addr(input logic [5:0] l);
      return {21'd0, l, 5'd0};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         model_ack <= 1'b0;
         cnt <= 0;
         for (int i = 0; i < 64; i++) mem_store[i] <= init_line(i);
      end else if (model_ack) begin
         model_ack <= 1'b0;
         cnt <= 0;
         bus.mem_data_i <= rand_line();
      end else if (bus.mem_enable_o) begin
         if (cnt >= lat_cfg - 1) begin
            model_ack <= 1'b1;
            cnt <= 0;
            if (bus.mem_write_o) mem_store[mline] <= bus.mem_data_o;
            else bus.mem_data_i <= mem_store[mline];
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.m0_req_i = 1'b0; bus.m0_write_i = 1'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
      bus.m1_req_i = 1'b0; bus.m1_write_i = 1'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0;
      spur_ack = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_line(i);
      ref_last = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      bus.mem_data_i = '0;
      lat_cfg = 4;
      rst = 1'b1;
      bus.m1_req_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", bus.mem_enable_o); end
      checks++; if (bus.mem_write_o !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", bus.mem_write_o); end
      checks++; if (bus.mem_addr_o !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr_o); end
      checks++; if (bus.mem_data_o !== 256'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.mem_data_o); end
      checks++; if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b%b exp=00", bus.m0_ack_o, bus.m1_ack_o); end
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
      bus.m1_req_i = 1'b0;
      do_reset();
   endtask

   task automatic test_single_read();
      int budget;
      logic m0_seen;
      do_reset();
      lat_cfg = 10;
      m0_seen = 1'b0;
      bus.m1_req_i = 1'b1; bus.m1_write_i = 1'b0; bus.m1_addr_i = 32'h40;
      @(negedge clk);
      checks++; if (bus.mem_enable_o !== 1'b1) begin failures++; $display("FAIL read_enable got=%b exp=1", bus.mem_enable_o); end
      checks++; if (bus.mem_addr_o !== 32'h40) begin failures++; $display("FAIL read_addr got=%h exp=40", bus.mem_addr_o); end
      checks++; if (bus.mem_write_o !== 1'b0) begin failures++; $display("FAIL read_write got=%b exp=0", bus.mem_write_o); end
      budget = 100;
      while (bus.m1_ack_o !== 1'b1 && budget > 0) begin
         if (bus.m0_ack_o === 1'b1) m0_seen = 1'b1;
         @(negedge clk);
         budget--;
      end
      checks++; if (budget == 0) begin failures++; $display("FAIL read_ack_timeout got=no_ack exp=m1_ack"); end
      checks++; if (bus.rdata_o !== ref_mem[2]) begin failures++; $display("FAIL read_rdata got=%h exp=%h", bus.rdata_o, ref_mem[2]); end
      bus.m1_req_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.m1_ack_o !== 1'b0 || bus.mem_enable_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         failures++; $display("FAIL read_release got=ack%b en%b busy%b exp=ack0 en0 busy1", bus.m1_ack_o, bus.mem_enable_o, bus.busy_o); end
      if (bus.m0_ack_o === 1'b1) m0_seen = 1'b1;
      @(negedge clk);
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL read_idle_busy got=%b exp=0", bus.busy_o); end
      checks++; if (m0_seen !== 1'b0) begin failures++; $display("FAIL read_m0_quiet got=%b exp=0", m0_seen); end
   endtask

   task automatic test_single_write();
      int budget;
      do_reset();
      lat_cfg = 3;
      bus.m0_req_i = 1'b1; bus.m0_write_i = 1'b1; bus.m0_addr_i = 32'h200; bus.m0_data_i = 256'h1234;
      @(negedge clk);
      checks++; if (bus.mem_write_o !== 1'b1) begin failures++; $display("FAIL write_strobe got=%b exp=1", bus.mem_write_o); end
      checks++; if (bus.mem_data_o !== 256'h1234) begin failures++; $display("FAIL write_data got=%h exp=1234", bus.mem_data_o); end
      checks++; if (bus.mem_addr_o !== 32'h200) begin failures++; $display("FAIL write_addr got=%h exp=200", bus.mem_addr_o); end
      budget = 100;
      while (bus.m0_ack_o !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
      checks++; if (budget == 0) begin failures++; $display("FAIL write_ack_timeout got=no_ack exp=m0_ack"); end
      ref_mem[16] = 256'h1234;
      bus.m0_req_i = 1'b0; bus.m0_write_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h200;
      budget = 100;
      while (bus.m0_ack_o !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
      checks++; if (budget == 0 || bus.rdata_o !== 256'h1234) begin
         failures++; $display("FAIL write_readback got=%h exp=1234", bus.rdata_o); end
      bus.m0_req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_tie();
      int budget;
      logic first;
      logic got;
      logic [ADDR_W-1:0] other_addr;
      do_reset();
      lat_cfg = 4;
`ifdef MEM_ARB_RR_EN
      first = ~ref_last;
`else
      first = 1'b1;
`endif
      bus.m0_req_i = 1'b1; bus.m0_write_i = 1'b0; bus.m0_addr_i = line_addr(6'd3);
      bus.m1_req_i = 1'b1; bus.m1_write_i = 1'b0; bus.m1_addr_i = line_addr(6'd5);
      other_addr = first ? line_addr(6'd3) : line_addr(6'd5);
      budget = 100;
      while (bus.m0_ack_o !== 1'b1 && bus.m1_ack_o !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
      got = bus.m1_ack_o;
      checks++; if (budget == 0 || got !== first) begin failures++; $display("FAIL tie_first got=%b exp=%b", got, first); end
      if (first) bus.m1_req_i = 1'b0; else bus.m0_req_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL tie_release got=%b exp=0", bus.mem_enable_o); end
      @(negedge clk);
      checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL tie_idle_gap got=%b exp=0", bus.mem_enable_o); end
      @(negedge clk);
      checks++; if (bus.mem_enable_o !== 1'b1 || bus.mem_addr_o !== other_addr) begin
         failures++; $display("FAIL tie_second_start got=en%b addr%h exp=en1 addr%h", bus.mem_enable_o, bus.mem_addr_o, other_addr); end
      // first winner re-requests while the other port is being served
      if (first) bus.m1_req_i = 1'b1; else bus.m0_req_i = 1'b1;
      budget = 100;
      while (bus.m0_ack_o !== 1'b1 && bus.m1_ack_o !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
      got = bus.m1_ack_o;
      checks++; if (budget == 0 || got !== ~first) begin failures++; $display("FAIL tie_second got=%b exp=%b", got, ~first); end
      if (first) bus.m0_req_i = 1'b0; else bus.m1_req_i = 1'b0;
      @(negedge clk);
      budget = 100;
      while (bus.m0_ack_o !== 1'b1 && bus.m1_ack_o !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
      got = bus.m1_ack_o;
      checks++; if (budget == 0 || got !== first) begin failures++; $display("FAIL tie_third got=%b exp=%b", got, first); end
      bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_churn();
      int budget;
      logic addr_bad;
      do_reset();
      lat_cfg = 8;
      addr_bad = 1'b0;
      bus.m1_req_i = 1'b1; bus.m1_write_i = 1'b0; bus.m1_addr_i = 32'h40;
      @(negedge clk);
      bus.m1_addr_i = 32'h80; bus.m1_write_i = 1'b1; bus.m1_data_i = rand_line();
      budget = 100;
      while (bus.m1_ack_o !== 1'b1 && budget > 0) begin
         if (bus.mem_addr_o !== 32'h40 || bus.mem_write_o !== 1'b0) addr_bad = 1'b1;
         @(negedge clk);
         budget--;
      end
      checks++; if (addr_bad !== 1'b0 || budget == 0) begin failures++; $display("FAIL churn_addr got=%h exp=40", bus.mem_addr_o); end
      checks++; if (bus.rdata_o !== ref_mem[2]) begin failures++; $display("FAIL churn_rdata got=%h exp=%h", bus.rdata_o, ref_mem[2]); end
      bus.m1_req_i = 1'b0; bus.m1_write_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_spurious_ack();
      do_reset();
      @(negedge clk);
      spur_ack = 1'b1;
      #1;
      checks++; if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin
         failures++; $display("FAIL spur_ack got=%b%b exp=00", bus.m0_ack_o, bus.m1_ack_o); end
      @(negedge clk);
      spur_ack = 1'b0;
      checks++; if (bus.busy_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
         failures++; $display("FAIL spur_state got=busy%b en%b exp=busy0 en0", bus.busy_o, bus.mem_enable_o); end
   endtask

   task automatic test_reset_mid_op();
      logic ack_seen;
      do_reset();
      lat_cfg = 30;
      ack_seen = 1'b0;
      bus.m0_req_i = 1'b1; bus.m0_write_i = 1'b0; bus.m0_addr_i = line_addr(6'd7);
      repeat (4) @(negedge clk);
      checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b exp=1", bus.busy_o); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.mem_enable_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.m0_ack_o !== 1'b0) begin
         failures++; $display("FAIL midrst_abort got=en%b busy%b ack%b exp=en0 busy0 ack0", bus.mem_enable_o, bus.busy_o, bus.m0_ack_o); end
      rst = 1'b0;
      bus.m0_req_i = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.m0_ack_o === 1'b1 || bus.m1_ack_o === 1'b1 || bus.busy_o === 1'b1) ack_seen = 1'b1;
      end
      checks++; if (ack_seen !== 1'b0) begin failures++; $display("FAIL midrst_quiet got=%b exp=0", ack_seen); end
   endtask

   task automatic test_random(input int rounds);
      logic [1:0]        want;
      logic              w [2];
      logic [5:0]        ln [2];
      logic [DATA_W-1:0] dd [2];
      logic [0:0]        exp_q [$];
      logic              first;
      logic              got;
      logic              expv;
      int                budget;
      do_reset();
      for (int r = 0; r < rounds; r++) begin
         want = 2'($urandom_range(1, 3));
         lat_cfg = $urandom_range(1, 6);
         for (int p = 0; p < 2; p++) begin
            w[p]  = 1'($urandom_range(0, 1));
            ln[p] = 6'($urandom_range(0, 63));
            dd[p] = rand_line();
         end
         bus.m0_req_i = want[0]; bus.m0_write_i = w[0]; bus.m0_addr_i = line_addr(ln[0]); bus.m0_data_i = dd[0];
         bus.m1_req_i = want[1]; bus.m1_write_i = w[1]; bus.m1_addr_i = line_addr(ln[1]); bus.m1_data_i = dd[1];
         if (want == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            first = ~ref_last;
`else
            first = 1'b1;
`endif
            exp_q.push_back(first);
            exp_q.push_back(~first);
         end else begin
            exp_q.push_back(want[1]);
         end
         ref_last = exp_q[$];
         budget = 400;
         while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.m0_ack_o === 1'b1 || bus.m1_ack_o === 1'b1) begin
               got = bus.m1_ack_o;
               expv = exp_q.pop_front();
               checks++;
               if ((bus.m0_ack_o === 1'b1 && bus.m1_ack_o === 1'b1) || got !== expv) begin
                  failures++; $display("FAIL rand_order round=%0d got=%b%b exp_port=%b", r, bus.m1_ack_o, bus.m0_ack_o, expv);
               end
               if (!w[got]) begin
                  checks++;
                  if (bus.rdata_o !== ref_mem[ln[got]]) begin
                     failures++; $display("FAIL rand_rdata round=%0d line=%0d got=%h exp=%h", r, ln[got], bus.rdata_o, ref_mem[ln[got]]);
                  end
               end else begin
                  ref_mem[ln[got]] = dd[got];
               end
               if (got) bus.m1_req_i = 1'b0; else bus.m0_req_i = 1'b0;
            end
         end
         if (exp_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL rand_timeout round=%0d got=%0d_acks_missing exp=0", r, exp_q.size());
            exp_q.delete();
            bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0;
         end
         @(negedge clk);
         @(negedge clk);
         checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rand_idle round=%0d got=%b exp=0", r, bus.busy_o); end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_tie();
      test_churn();
      test_spurious_ack();
      test_reset_mid_op();
      test_random(60);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
